// File: rtl/rom_128x16.sv
// 128 x 16 read-only instruction/data image, registered address (1-cycle read),
// optional output register (2-cycle read). Contents: word i holds 10*i.
module rom_128x16 #(
   parameter int OUT_REG = 0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [6:0]  address,
   output logic [15:0] q
);

   localparam int ADDR_W = 7;
   localparam int DATA_W = 16;

   // Power-up value keeps q defined before the first edge.
   logic [ADDR_W-1:0] r_addr = '0;
   logic [DATA_W-1:0] w_rom;

   always_ff @(posedge Clk) begin
      if (Reset) r_addr <= '0;
      else       r_addr <= address;
   end

   always_comb begin
      w_rom = '0;
      case (r_addr)
         7'd0:   w_rom = 16'd0;    7'd1:   w_rom = 16'd10;   7'd2:   w_rom = 16'd20;   7'd3:   w_rom = 16'd30;
         7'd4:   w_rom = 16'd40;   7'd5:   w_rom = 16'd50;   7'd6:   w_rom = 16'd60;   7'd7:   w_rom = 16'd70;
         7'd8:   w_rom = 16'd80;   7'd9:   w_rom = 16'd90;   7'd10:  w_rom = 16'd100;  7'd11:  w_rom = 16'd110;
         7'd12:  w_rom = 16'd120;  7'd13:  w_rom = 16'd130;  7'd14:  w_rom = 16'd140;  7'd15:  w_rom = 16'd150;
         7'd16:  w_rom = 16'd160;  7'd17:  w_rom = 16'd170;  7'd18:  w_rom = 16'd180;  7'd19:  w_rom = 16'd190;
         7'd20:  w_rom = 16'd200;  7'd21:  w_rom = 16'd210;  7'd22:  w_rom = 16'd220;  7'd23:  w_rom = 16'd230;
         7'd24:  w_rom = 16'd240;  7'd25:  w_rom = 16'd250;  7'd26:  w_rom = 16'd260;  7'd27:  w_rom = 16'd270;
         7'd28:  w_rom = 16'd280;  7'd29:  w_rom = 16'd290;  7'd30:  w_rom = 16'd300;  7'd31:  w_rom = 16'd310;
         7'd32:  w_rom = 16'd320;  7'd33:  w_rom = 16'd330;  7'd34:  w_rom = 16'd340;  7'd35:  w_rom = 16'd350;
         7'd36:  w_rom = 16'd360;  7'd37:  w_rom = 16'd370;  7'd38:  w_rom = 16'd380;  7'd39:  w_rom = 16'd390;
         7'd40:  w_rom = 16'd400;  7'd41:  w_rom = 16'd410;  7'd42:  w_rom = 16'd420;  7'd43:  w_rom = 16'd430;
         7'd44:  w_rom = 16'd440;  7'd45:  w_rom = 16'd450;  7'd46:  w_rom = 16'd460;  7'd47:  w_rom = 16'd470;
         7'd48:  w_rom = 16'd480;  7'd49:  w_rom = 16'd490;  7'd50:  w_rom = 16'd500;  7'd51:  w_rom = 16'd510;
         7'd52:  w_rom = 16'd520;  7'd53:  w_rom = 16'd530;  7'd54:  w_rom = 16'd540;  7'd55:  w_rom = 16'd550;
         7'd56:  w_rom = 16'd560;  7'd57:  w_rom = 16'd570;  7'd58:  w_rom = 16'd580;  7'd59:  w_rom = 16'd590;
         7'd60:  w_rom = 16'd600;  7'd61:  w_rom = 16'd610;  7'd62:  w_rom = 16'd620;  7'd63:  w_rom = 16'd630;
         7'd64:  w_rom = 16'd640;  7'd65:  w_rom = 16'd650;  7'd66:  w_rom = 16'd660;  7'd67:  w_rom = 16'd670;
         7'd68:  w_rom = 16'd680;  7'd69:  w_rom = 16'd690;  7'd70:  w_rom = 16'd700;  7'd71:  w_rom = 16'd710;
         7'd72:  w_rom = 16'd720;  7'd73:  w_rom = 16'd730;  7'd74:  w_rom = 16'd740;  7'd75:  w_rom = 16'd750;
         7'd76:  w_rom = 16'd760;  7'd77:  w_rom = 16'd770;  7'd78:  w_rom = 16'd780;  7'd79:  w_rom = 16'd790;
         7'd80:  w_rom = 16'd800;  7'd81:  w_rom = 16'd810;  7'd82:  w_rom = 16'd820;  7'd83:  w_rom = 16'd830;
         7'd84:  w_rom = 16'd840;  7'd85:  w_rom = 16'd850;  7'd86:  w_rom = 16'd860;  7'd87:  w_rom = 16'd870;
         7'd88:  w_rom = 16'd880;  7'd89:  w_rom = 16'd890;  7'd90:  w_rom = 16'd900;  7'd91:  w_rom = 16'd910;
         7'd92:  w_rom = 16'd920;  7'd93:  w_rom = 16'd930;  7'd94:  w_rom = 16'd940;  7'd95:  w_rom = 16'd950;
         7'd96:  w_rom = 16'd960;  7'd97:  w_rom = 16'd970;  7'd98:  w_rom = 16'd980;  7'd99:  w_rom = 16'd990;
         7'd100: w_rom = 16'd1000; 7'd101: w_rom = 16'd1010; 7'd102: w_rom = 16'd1020; 7'd103: w_rom = 16'd1030;
         7'd104: w_rom = 16'd1040; 7'd105: w_rom = 16'd1050; 7'd106: w_rom = 16'd1060; 7'd107: w_rom = 16'd1070;
         7'd108: w_rom = 16'd1080; 7'd109: w_rom = 16'd1090; 7'd110: w_rom = 16'd1100; 7'd111: w_rom = 16'd1110;
         7'd112: w_rom = 16'd1120; 7'd113: w_rom = 16'd1130; 7'd114: w_rom = 16'd1140; 7'd115: w_rom = 16'd1150;
         7'd116: w_rom = 16'd1160; 7'd117: w_rom = 16'd1170; 7'd118: w_rom = 16'd1180; 7'd119: w_rom = 16'd1190;
         7'd120: w_rom = 16'd1200; 7'd121: w_rom = 16'd1210; 7'd122: w_rom = 16'd1220; 7'd123: w_rom = 16'd1230;
         7'd124: w_rom = 16'd1240; 7'd125: w_rom = 16'd1250; 7'd126: w_rom = 16'd1260; 7'd127: w_rom = 16'd1270;
      endcase
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] r_q = '0;
         always_ff @(posedge Clk) begin
            if (Reset) r_q <= '0;
            else       r_q <= w_rom;
         end
         assign q = r_q;
      end else begin : g_comb
         assign q = w_rom;
      end
   endgenerate

endmodule

// File: tb/tb_rom_128x16.sv
// Bench for rom_128x16: both OUT_REG settings side by side, fixed vector table,
// sweep/wrap/reset sequences and random addresses against a ROM=10*i model.
module tb_rom_128x16;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic [6:0]  address = '0;
   logic [15:0] q0, q1;

   int checks = 0;
   int errors = 0;
   int m0 = 0;   // expected q for the unregistered-output instance
   int m1 = 0;   // expected q for the registered-output instance

   always #5 Clk = ~Clk;

   rom_128x16 #(.OUT_REG(0)) dut0 (.Clk(Clk), .Reset(Reset), .address(address), .q(q0));
   rom_128x16 #(.OUT_REG(1)) dut1 (.Clk(Clk), .Reset(Reset), .address(address), .q(q1));

   typedef struct {
      logic        rst;
      logic [6:0]  addr;
      logic [15:0] exp0;
      logic [15:0] exp1;
   } vec_t;

   function automatic int rom_ref(input int a);
      return (10 * a) % 65536;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input int exp);
      checks++;
      if (act !== 16'(exp)) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   // Drive one cycle's inputs, clock it in, sample 1 time unit after the edge.
   task automatic step(input logic rst, input logic [6:0] a);
      @(negedge Clk);
      Reset = rst;
      address = a;
      @(posedge Clk);
      #1;
      m1 = rst ? 0 : m0;
      m0 = rst ? 0 : rom_ref(int'(a));
   endtask

   task automatic step_chk(input logic rst, input logic [6:0] a, input string nm);
      step(rst, a);
      chk($sformatf("%s_q0_a%0d", nm, a), q0, m0);
      chk($sformatf("%s_q1_a%0d", nm, a), q1, m1);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{1'b1, 7'd55,  16'd0,    16'd0};
      vecs[1] = '{1'b0, 7'd1,   16'd10,   16'd0};
      vecs[2] = '{1'b0, 7'd1,   16'd10,   16'd10};
      vecs[3] = '{1'b0, 7'd127, 16'd1270, 16'd10};
      vecs[4] = '{1'b0, 7'd0,   16'd0,    16'd1270};
      vecs[5] = '{1'b0, 7'd1,   16'd10,   16'd0};
      vecs[6] = '{1'b1, 7'd40,  16'd0,    16'd0};
      vecs[7] = '{1'b0, 7'd64,  16'd640,  16'd0};
      vecs[8] = '{1'b0, 7'd100, 16'd1000, 16'd640};
      vecs[9] = '{1'b1, 7'd5,   16'd0,    16'd0};

      // Power-up state, before any edge
      #1;
      chk("powerup_q0", q0, 0);
      chk("powerup_q1", q1, 0);

      // Reset held 10 cycles with a nonzero address
      for (int i = 0; i < 10; i++) step_chk(1'b1, 7'd55, "reset");

      // Fixed vectors
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].rst, vecs[i].addr);
         chk($sformatf("vec%0d_q0", i), q0, int'(vecs[i].exp0));
         chk($sformatf("vec%0d_q1", i), q1, int'(vecs[i].exp1));
      end

      // Sequential sweep with wrap 127 -> 0 -> 1
      for (int k = 0; k < 128; k++) step_chk(1'b0, 7'(k), "sweep");
      step_chk(1'b0, 7'd0, "wrap");
      step_chk(1'b0, 7'd1, "wrap");

      // Mid-sweep reset at address 40, then resume
      for (int k = 30; k < 40; k++) step_chk(1'b0, 7'(k), "pre");
      step_chk(1'b1, 7'd40, "midrst");
      for (int k = 41; k < 50; k++) step_chk(1'b0, 7'(k), "resume");

      // OUT_REG=1 latency with a held address, then reset clears q
      step_chk(1'b1, 7'd0, "lat_rst");
      step_chk(1'b0, 7'd1, "lat_e1");
      chk("lat_e1_q1_zero", q1, 0);
      step_chk(1'b0, 7'd1, "lat_e2");
      chk("lat_e2_q1_ten", q1, 10);
      step_chk(1'b1, 7'd1, "lat_clr");
      chk("lat_clr_q1_zero", q1, 0);

      // Random addresses, occasional reset
      for (int i = 0; i < 500; i++)
         step_chk(($urandom_range(0, 31) == 0), 7'($urandom_range(0, 127)), "rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
